// File: rtl/rr_arbiter16_if.sv
// Request/grant bundle between the 16 requesters and the round-robin arbiter.
// The master side raises requests and done; the slave side (the arbiter) drives the grant.
interface rr_arbiter16_if;
  logic [15:0] req;
  logic        done;
  logic [3:0]  gnt_idx;
  logic        gnt_vld;
  logic [15:0] gnt;
  logic        tmo;

  modport master (
    output req,
    output done,
    input  gnt_idx,
    input  gnt_vld,
    input  gnt,
    input  tmo
  );

  modport slave (
    input  req,
    input  done,
    output gnt_idx,
    output gnt_vld,
    output gnt,
    output tmo
  );
endinterface

// File: rtl/rr_arbiter16.sv
// Round-robin arbiter for one 16-way resource: grants one requester at a time,
// bounds each grant to MAX_HOLD cycles, and rotates priority after every release.
module rr_arbiter16 #(
  parameter int MAX_HOLD = 8
) (
  input  logic          clk,
  input  logic          rst,
  rr_arbiter16_if.slave arb
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t      state_q, state_d;
  logic [3:0]  ptr_q, ptr_d;
  logic [7:0]  hcnt_q, hcnt_d;
  logic [3:0]  idx_q, idx_d;
  logic        vld_q, vld_d;
  logic [15:0] gnt_q, gnt_d;
  logic        tmo_q, tmo_d;

  logic        win_found;
  logic [3:0]  win_idx;
  logic [3:0]  cand;
  logic        hold_expired;
  logic        grant_release;

  // Scan starts at ptr and wraps, so the first hit is the highest-priority requester.
  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr_q;
    cand      = '0;
    for (int k = 0; k < 16; k++) begin
      cand = ptr_q + 4'(k);
      if (!win_found && arb.req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign hold_expired  = (hcnt_q == HOLD_LAST);
  assign grant_release = arb.done || !arb.req[idx_q] || hold_expired;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    hcnt_d  = hcnt_q;
    idx_d   = idx_q;
    vld_d   = vld_q;
    gnt_d   = gnt_q;
    tmo_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d = GRANT;
          idx_d   = win_idx;
          vld_d   = 1'b1;
          gnt_d   = 16'(1) << win_idx;
          hcnt_d  = 8'd0;
        end
      end
      GRANT: begin
        if (grant_release) begin
          state_d = IDLE;
          vld_d   = 1'b0;
          gnt_d   = 16'h0000;
          ptr_d   = idx_q + 4'd1;
          // A timeout only counts as forced when the grantee neither finished nor withdrew.
          tmo_d   = hold_expired && !arb.done && arb.req[idx_q];
        end else begin
          hcnt_d = hcnt_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        vld_d   = 1'b0;
        gnt_d   = 16'h0000;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 4'd0;
      hcnt_q  <= 8'd0;
      idx_q   <= 4'd0;
      vld_q   <= 1'b0;
      gnt_q   <= 16'h0000;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      hcnt_q  <= hcnt_d;
      idx_q   <= idx_d;
      vld_q   <= vld_d;
      gnt_q   <= gnt_d;
      tmo_q   <= tmo_d;
    end
  end

  assign arb.gnt_idx = idx_q;
  assign arb.gnt_vld = vld_q;
  assign arb.gnt     = gnt_q;
  assign arb.tmo     = tmo_q;

endmodule

// File: tb/tb_rr_arbiter16.sv
// Directed bench for rr_arbiter16: rotation order, wrap, hold timeout,
// request withdrawal, mid-grant reset, and a MAX_HOLD=1 instance.
module tb_rr_arbiter16;

  logic clk;
  logic rst;
  int   check_count;
  int   err_count;

  rr_arbiter16_if arb_if ();
  rr_arbiter16_if arb1_if ();

  rr_arbiter16 #(.MAX_HOLD(8)) dut (
    .clk (clk),
    .rst (rst),
    .arb (arb_if.slave)
  );

  rr_arbiter16 #(.MAX_HOLD(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .arb (arb1_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      err_count++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] req, input logic done);
    arb_if.req  = req;
    arb_if.done = done;
  endtask

  task automatic resetAll();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic checkGrant(input string tag, input logic [3:0] idx);
    checkOutput({tag, "_vld"}, 32'(arb_if.gnt_vld), 32'd1);
    checkOutput({tag, "_idx"}, 32'(arb_if.gnt_idx), 32'(idx));
    checkOutput({tag, "_gnt"}, 32'(arb_if.gnt), 32'(16'h0001 << idx));
  endtask

  task automatic checkIdle(input string tag, input logic tmo);
    checkOutput({tag, "_vld"}, 32'(arb_if.gnt_vld), 32'd0);
    checkOutput({tag, "_gnt"}, 32'(arb_if.gnt), 32'd0);
    checkOutput({tag, "_tmo"}, 32'(arb_if.tmo), 32'(tmo));
  endtask

  // One full grant: granted on the idle edge, released by a one-cycle done pulse.
  task automatic grantCycle(input string tag, input logic [3:0] idx);
    tick();
    checkGrant(tag, idx);
    arb_if.done = 1'b1;
    tick();
    checkIdle({tag, "_rel"}, 1'b0);
    arb_if.done = 1'b0;
  endtask

  initial begin
    check_count  = 0;
    err_count    = 0;
    rst          = 1'b1;
    applyStimulus(16'h0000, 1'b0);
    arb1_if.req  = 16'h0000;
    arb1_if.done = 1'b0;

    tick();
    checkIdle("reset", 1'b0);
    checkOutput("reset_idx", 32'(arb_if.gnt_idx), 32'd0);
    rst = 1'b0;

    applyStimulus(16'h0001, 1'b0);
    tick();
    checkGrant("single", 4'd0);
    applyStimulus(16'h0000, 1'b1);
    tick();
    checkIdle("single_rel", 1'b0);
    applyStimulus(16'h0000, 1'b0);
    tick();
    checkIdle("no_req", 1'b0);

    resetAll();
    applyStimulus(16'hFFFF, 1'b0);
    for (int n = 0; n < 17; n++) grantCycle($sformatf("rr%0d", n), 4'(n));

    resetAll();
    applyStimulus(16'hFFFF, 1'b0);
    for (int n = 0; n < 15; n++) grantCycle($sformatf("pre%0d", n), 4'(n));
    applyStimulus(16'h8001, 1'b0);
    grantCycle("wrap15", 4'd15);
    grantCycle("wrap0", 4'd0);

    resetAll();
    applyStimulus(16'h0011, 1'b0);
    for (int n = 0; n < 8; n++) begin
      tick();
      checkGrant($sformatf("hold%0d", n), 4'd0);
      checkOutput($sformatf("hold%0d_tmo", n), 32'(arb_if.tmo), 32'd0);
    end
    tick();
    checkIdle("timeout", 1'b1);
    tick();
    checkGrant("after_tmo", 4'd4);
    checkOutput("after_tmo_tmo", 32'(arb_if.tmo), 32'd0);
    applyStimulus(16'h0000, 1'b1);
    tick();
    applyStimulus(16'h0000, 1'b0);

    resetAll();
    applyStimulus(16'h0008, 1'b0);
    tick();
    checkGrant("drop_c1", 4'd3);
    tick();
    tick();
    checkGrant("drop_c3", 4'd3);
    applyStimulus(16'h0000, 1'b0);
    tick();
    checkIdle("drop_rel", 1'b0);
    applyStimulus(16'hFFFF, 1'b0);
    tick();
    checkGrant("drop_ptr", 4'd4);
    applyStimulus(16'h0000, 1'b1);
    tick();
    applyStimulus(16'h0000, 1'b0);

    applyStimulus(16'h0200, 1'b0);
    tick();
    checkGrant("rst_c1", 4'd9);
    for (int n = 0; n < 4; n++) tick();
    checkGrant("rst_c5", 4'd9);
    rst = 1'b1;
    tick();
    checkIdle("mid_rst", 1'b0);
    checkOutput("mid_rst_idx", 32'(arb_if.gnt_idx), 32'd0);
    rst = 1'b0;
    applyStimulus(16'h0100, 1'b0);
    tick();
    checkGrant("post_rst", 4'd8);
    applyStimulus(16'h0000, 1'b0);
    tick();
    checkIdle("post_rst_drop", 1'b0);

    resetAll();
    arb1_if.req = 16'h0003;
    tick();
    checkOutput("mh1_g0_vld", 32'(arb1_if.gnt_vld), 32'd1);
    checkOutput("mh1_g0_idx", 32'(arb1_if.gnt_idx), 32'd0);
    tick();
    checkOutput("mh1_r0_vld", 32'(arb1_if.gnt_vld), 32'd0);
    checkOutput("mh1_r0_tmo", 32'(arb1_if.tmo), 32'd1);
    tick();
    checkOutput("mh1_g1_idx", 32'(arb1_if.gnt_idx), 32'd1);
    checkOutput("mh1_g1_gnt", 32'(arb1_if.gnt), 32'h0002);
    checkOutput("mh1_g1_tmo", 32'(arb1_if.tmo), 32'd0);
    arb1_if.done = 1'b1;
    tick();
    checkOutput("mh1_r1_vld", 32'(arb1_if.gnt_vld), 32'd0);
    checkOutput("mh1_r1_tmo", 32'(arb1_if.tmo), 32'd0);
    arb1_if.done = 1'b0;
    arb1_if.req  = 16'h0000;

    $display("CHECKS %0d ERRORS %0d", check_count, err_count);
    $finish;
  end

endmodule
